cdc_fifo_push_arbiter: RTL and testbench
========================================

Name: cdc_fifo_push_arbiter

Overview:
Round-robin packet arbiter in source clock domain A. It shares the push side of one CDC FIFO between NumReq producers. Each granted packet is held atomically until its last beat. Each beat is tagged with the requester index so the B-domain consumer can demultiplex. The block drives the FIFO's push and data-in ports and obeys its full flag.

Parameters:
NumReq, 4, number of requesters (1..16)
DataWidth, 32, payload bits per beat
MaxBeats, 16, beat cap per grant; 0 = unlimited
IdWidth (localparam), (NumReq==1) ? 1 : clog2(NumReq), width of the tag field

Ports:
clk_DA  in  1  domain-A clock, all logic on posedge
rst_n  in  1  asynchronous reset, active-low
Req_Valid_DA  in  NumReq  per-requester beat valid
Req_Last_DA  in  NumReq  per-requester last beat of packet, qualified by valid
Req_Data_DA  in  NumReq*DataWidth  packed payloads; requester i occupies [i*DataWidth +: DataWidth]
Req_Ready_DA  out  NumReq  per-requester beat accepted this cycle when valid
FifoFull_DA  in  1  full flag from the CDC FIFO
Push_DA  out  1  push strobe to the FIFO
DataIn_DA  out  IdWidth+DataWidth  {grant index, payload} to the FIFO
Grant_DA  out  NumReq  one-hot current grant; 0 when idle
Busy_DA  out  1  high while in BUSY
Trunc_DA  out  1  sticky: a packet was force-released at MaxBeats

Behaviour:
- Reset (rst_n low, async):
  - State=IDLE; Grant_DA=0; RrPtr=0; BeatCnt=0; Trunc_DA=0.
  - Push_DA=0, Req_Ready_DA=0, Busy_DA=0, DataIn_DA=0.
  - These values take effect immediately on rst_n falling, with no clock required.
  - Any packet in flight is abandoned; no partial-push recovery.
- Handshake rules:
  - A beat transfers when Req_Valid_DA[g] & Req_Ready_DA[g].
  - A requester must hold data and last stable while valid and not ready.
  - A requester may drop valid mid-packet. The grant is held and no push occurs; there is no timeout.
- IDLE:
  - Ready=0, Push=0.
  - If any valid, select the first valid index scanning RrPtr, RrPtr+1, ... with wrap.
  - Next edge: Grant_DA=onehot(sel), state BUSY, BeatCnt=0.
  - Arbitration latency is 1 cycle; there are no transfers in IDLE.
- BUSY, grant g (combinational outputs):
  - Req_Ready_DA[g] = !FifoFull_DA; all other ready bits 0.
  - Push_DA = Req_Valid_DA[g] & !FifoFull_DA. Push_DA is never high while FifoFull_DA=1.
  - DataIn_DA = {g[IdWidth-1:0], Req_Data_DA[g]}; DataIn_DA=0 in IDLE.
  - Accepted beat: BeatCnt <= BeatCnt+1.
- Release, on an accepted beat where Req_Last_DA[g]=1, or where MaxBeats!=0 and BeatCnt==MaxBeats-1:
  - RrPtr <= (g==NumReq-1) ? 0 : g+1.
  - Re-arbitrate in the same edge over the current Req_Valid_DA, scanning from g+1 with wrap. g is therefore lowest priority.
  - If a winner exists: Grant <= onehot(winner), stay BUSY, BeatCnt=0. This gives back-to-back packets with zero bubble.
  - Otherwise go to IDLE with Grant=0.
  - Forced release (cap reached without Last) sets Trunc_DA=1 until reset. The requester's remaining beats form a new packet at a later grant.
- BeatCnt width is clog2(MaxBeats+1) (min 1). It never exceeds MaxBeats-1 at compare time.
- Simultaneous last beat and FifoFull_DA=1: no transfer, so no release; the grant is held.
- Only state, Grant, RrPtr, BeatCnt and Trunc are registered.

Test Plan:
1. Req0 sends a 2-beat packet (D0=0xA, D1=0xB, last on D1), FIFO never full, req0 valid from cycle 0 → Grant_DA=0001 at cycle 1. Push_DA=1 in cycles 1–2 with DataIn_DA={2'd0,0xA} then {2'd0,0xB}. Busy_DA=0 at cycle 3.
2. Req0 and req2 each valid with 3-beat packets at cycle 0 → req0 beats pushed in cycles 1–3, req2 beats in cycles 4–6 (no bubble, tag 2). Beats from the two requesters never interleave.
3. All 4 requesters continuously valid with 1-beat packets → grant sequence 0,1,2,3,0,1... with one push per cycle after cycle 1.
4. Req1 packet of 4 beats; FifoFull_DA=1 during cycles 2–4 → Push_DA=0 and Req_Ready_DA=0 during the stall. Grant is held at 0010. All 4 beats reach the FIFO in order, with none lost or duplicated.
5. MaxBeats=4; req3 sends 6 beats without last, req0 valid → after req3's 4th beat Grant_DA=0001 on the next cycle and Trunc_DA=1. Req3 is re-granted after req0's packet.
6. rst_n driven low mid-packet between clock edges → Push_DA, Req_Ready_DA and Grant_DA are 0 immediately. After release, the first grant goes to the lowest valid index (RrPtr=0).

Source files
------------

// File: rtl/cdc_fifo_push_arbiter.sv
// Round-robin push-side arbiter for a shared CDC FIFO in clock domain A.
// Grants are packet-atomic, and each pushed beat is tagged with its requester index.
module cdc_fifo_push_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int MaxBeats  = 16,
    localparam int IdWidth  = (NumReq == 1) ? 1 : $clog2(NumReq)
) (
    input  logic                           clk_DA,
    input  logic                           rst_n,
    input  logic [NumReq-1:0]              Req_Valid_DA,
    input  logic [NumReq-1:0]              Req_Last_DA,
    input  logic [NumReq*DataWidth-1:0]    Req_Data_DA,
    output logic [NumReq-1:0]              Req_Ready_DA,
    input  logic                           FifoFull_DA,
    output logic                           Push_DA,
    output logic [IdWidth+DataWidth-1:0]   DataIn_DA,
    output logic [NumReq-1:0]              Grant_DA,
    output logic                           Busy_DA,
    output logic                           Trunc_DA
);

    localparam int CntWidth = (MaxBeats == 0) ? 1 : $clog2(MaxBeats + 1);
    localparam int CapVal   = (MaxBeats == 0) ? 0 : MaxBeats - 1;
    localparam logic [CntWidth-1:0] CapCnt = CntWidth'(CapVal);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic [NumReq-1:0]     grant;
    logic [IdWidth-1:0]    gidx;
    logic [IdWidth-1:0]    rr_ptr;
    logic [CntWidth-1:0]   beat_cnt;
    logic                  trunc;

    logic [DataWidth-1:0]  req_data [NumReq];
    logic [IdWidth-1:0]    next_g;
    logic [IdWidth-1:0]    scan_start;
    logic [IdWidth:0]      cand;
    logic [IdWidth-1:0]    win_idx;
    logic                  win_found;
    logic [NumReq-1:0]     win_onehot;
    logic                  busy;
    logic                  accept;
    logic                  last_g;
    logic                  cap_hit;
    logic                  rel;

    for (genvar i = 0; i < NumReq; i++) begin : g_unpack
        assign req_data[i] = Req_Data_DA[i*DataWidth +: DataWidth];
    end

    // The same scanner serves IDLE arbitration (from rr_ptr) and same-edge
    // re-arbitration at release (from g+1, so the finishing owner is last).
    always_comb begin
        next_g     = (gidx == IdWidth'(NumReq - 1)) ? '0 : gidx + 1'b1;
        scan_start = (state == IDLE) ? rr_ptr : next_g;
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = {1'b0, scan_start} + (IdWidth+1)'(k);
            if (cand >= (IdWidth+1)'(NumReq)) begin
                cand = cand - (IdWidth+1)'(NumReq);
            end
            if (!win_found && Req_Valid_DA[cand[IdWidth-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdWidth-1:0];
            end
        end
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    assign busy    = (state == BUSY);
    assign accept  = busy && |(Req_Valid_DA & grant) && !FifoFull_DA;
    assign last_g  = |(Req_Last_DA & grant);
    assign cap_hit = (MaxBeats != 0) && (beat_cnt == CapCnt);
    assign rel     = accept && (last_g || cap_hit);

    assign Req_Ready_DA = (busy && !FifoFull_DA) ? grant : '0;
    assign Push_DA      = accept;
    assign DataIn_DA    = busy ? {gidx, req_data[gidx]} : '0;
    assign Grant_DA     = grant;
    assign Busy_DA      = busy;
    assign Trunc_DA     = trunc;

    always_ff @(posedge clk_DA or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            gidx     <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            trunc    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= BUSY;
                        grant    <= win_onehot;
                        gidx     <= win_idx;
                        beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        rr_ptr   <= next_g;
                        beat_cnt <= '0;
                        if (!last_g) begin
                            trunc <= 1'b1;
                        end
                        if (win_found) begin
                            grant <= win_onehot;
                            gidx  <= win_idx;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_fifo_push_arbiter.sv
// Randomized bench for cdc_fifo_push_arbiter: per-requester beat scoreboard
// plus a cycle-level round-robin model of grant/ready/push/trunc.
module tb_cdc_fifo_push_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int IW = 2;

    logic                clk_DA = 1'b0;
    logic                rst_n;
    logic [N-1:0]        Req_Valid_DA;
    logic [N-1:0]        Req_Last_DA;
    logic [N*DW-1:0]     Req_Data_DA;
    logic [N-1:0]        Req_Ready_DA;
    logic                FifoFull_DA;
    logic                Push_DA;
    logic [IW+DW-1:0]    DataIn_DA;
    logic [N-1:0]        Grant_DA;
    logic                Busy_DA;
    logic                Trunc_DA;

    always #5 clk_DA = ~clk_DA;

    cdc_fifo_push_arbiter #(.NumReq(N), .DataWidth(DW), .MaxBeats(MB)) dut (
        .clk_DA       (clk_DA),
        .rst_n        (rst_n),
        .Req_Valid_DA (Req_Valid_DA),
        .Req_Last_DA  (Req_Last_DA),
        .Req_Data_DA  (Req_Data_DA),
        .Req_Ready_DA (Req_Ready_DA),
        .FifoFull_DA  (FifoFull_DA),
        .Push_DA      (Push_DA),
        .DataIn_DA    (DataIn_DA),
        .Grant_DA     (Grant_DA),
        .Busy_DA      (Busy_DA),
        .Trunc_DA     (Trunc_DA)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q [N][$];
    int            left [N];
    logic [N-1:0]  acc;
    bit            no_new = 1'b0;

    int            m_owner, m_ptr, m_cnt, m_w;
    bit            m_trunc, m_acc, m_last;
    logic [63:0]   m_grant, m_ready;
    int            m_tag;
    logic [DW-1:0] m_data;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Each requester keeps a valid beat up until it is accepted; new beats
    // and packets appear with the given probabilities (percent).
    task automatic applyStimulus(input logic [N-1:0] mask, input int minl, input int maxl,
                                 input int vpct, input int fpct, input int cycles);
        logic [DW-1:0] d;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_DA);
            acc = Req_Valid_DA & Req_Ready_DA;
            @(posedge clk_DA);
            #1;
            FifoFull_DA = (int'($urandom_range(99)) < fpct);
            for (int i = 0; i < N; i++) begin
                if (Req_Valid_DA[i] && acc[i]) begin
                    Req_Valid_DA[i] = 1'b0;
                    left[i]--;
                end
                if (!Req_Valid_DA[i]) begin
                    if (left[i] == 0 && mask[i] && !no_new && int'($urandom_range(99)) < vpct) begin
                        left[i] = int'($urandom_range(maxl, minl));
                    end
                    if (left[i] > 0 && int'($urandom_range(99)) < vpct) begin
                        d = $urandom;
                        Req_Data_DA[i*DW +: DW] = d;
                        Req_Last_DA[i]  = (left[i] == 1);
                        Req_Valid_DA[i] = 1'b1;
                        exp_q[i].push_back(d);
                    end
                end
            end
        end
    endtask

    // Monitor: compares outputs against the model, pops the scoreboard on
    // every push, then advances the model using this cycle's inputs.
    always @(negedge clk_DA) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_trunc = 1'b0;
        end else begin
            m_grant = (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0;
            m_ready = (m_owner >= 0 && !FifoFull_DA) ? m_grant : 64'd0;
            m_acc   = (m_owner >= 0) && Req_Valid_DA[m_owner] && !FifoFull_DA;
            m_last  = (m_owner >= 0) && Req_Last_DA[m_owner];
            checkOutput("grant", 64'(Grant_DA), m_grant);
            checkOutput("ready", 64'(Req_Ready_DA), m_ready);
            checkOutput("push", 64'(Push_DA), 64'(m_acc));
            checkOutput("busy", 64'(Busy_DA), 64'(m_owner >= 0));
            checkOutput("trunc", 64'(Trunc_DA), 64'(m_trunc));
            if (m_owner < 0) checkOutput("datain_idle", 64'(DataIn_DA), 64'd0);
            if (Push_DA) begin
                m_tag  = int'(DataIn_DA[DW +: IW]);
                m_data = DataIn_DA[DW-1:0];
                checkOutput("push_tag", 64'(m_tag), 64'(m_owner));
                if (exp_q[m_tag].size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL push_unexpected: tag %0d data %0h with no beat outstanding", m_tag, m_data);
                end else begin
                    checkOutput("push_data", 64'(m_data), 64'(exp_q[m_tag].pop_front()));
                end
            end
            if (m_owner < 0) begin
                m_w = pick(Req_Valid_DA, m_ptr);
                if (m_w >= 0) begin
                    m_owner = m_w;
                    m_cnt   = 0;
                end
            end else if (m_acc) begin
                m_cnt++;
                if (m_last || m_cnt == MB) begin
                    if (!m_last) m_trunc = 1'b1;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = pick(Req_Valid_DA, m_ptr);
                    m_cnt   = 0;
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        Req_Valid_DA = '0;
        Req_Last_DA  = '0;
        Req_Data_DA  = '0;
        FifoFull_DA  = 1'b0;
        for (int i = 0; i < N; i++) left[i] = 0;
        #1;
        checkOutput("rst_grant", 64'(Grant_DA), 64'd0);
        checkOutput("rst_push", 64'(Push_DA), 64'd0);
        checkOutput("rst_ready", 64'(Req_Ready_DA), 64'd0);
        checkOutput("rst_busy", 64'(Busy_DA), 64'd0);
        checkOutput("rst_datain", 64'(DataIn_DA), 64'd0);
        checkOutput("rst_trunc", 64'(Trunc_DA), 64'd0);
        #21 rst_n = 1'b1;

        applyStimulus(4'b0001, 2, 2, 100, 0, 8);
        applyStimulus(4'b0101, 3, 3, 100, 0, 20);
        applyStimulus(4'b1111, 1, 1, 100, 0, 20);
        applyStimulus(4'b0010, 4, 4, 100, 40, 20);
        applyStimulus(4'b1001, 6, 6, 100, 0, 30);
        checkOutput("trunc_after_cap", 64'(Trunc_DA), 64'd1);
        applyStimulus(4'b1111, 1, 7, 70, 25, 1500);

        // Asynchronous reset in the middle of a busy period, between edges.
        applyStimulus(4'b1111, 3, 6, 100, 0, 5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_push", 64'(Push_DA), 64'd0);
        checkOutput("arst_ready", 64'(Req_Ready_DA), 64'd0);
        checkOutput("arst_grant", 64'(Grant_DA), 64'd0);
        checkOutput("arst_busy", 64'(Busy_DA), 64'd0);
        checkOutput("arst_trunc", 64'(Trunc_DA), 64'd0);
        applyStimulus(4'b1111, 3, 6, 100, 0, 2);
        #2 rst_n = 1'b1;
        applyStimulus(4'b1111, 1, 7, 80, 20, 300);

        no_new = 1'b1;
        applyStimulus(4'b0000, 1, 1, 100, 0, 300);
        for (int i = 0; i < N; i++) begin
            checkOutput("drain_queue", 64'(exp_q[i].size()), 64'd0);
            checkOutput("drain_left", 64'(left[i]), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
